// File: rtl/program_loader_if.sv
// Host byte link plus the loader's memory write ports and core control.
// The host side is the master; the loader is the slave of the byte stream.
interface program_loader_if #(
   parameter int IMEM_AW = 12,
   parameter int DMEM_AW = 10
);
   logic               in_valid;
   logic [7:0]         in_data;
   logic               in_ready;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_wdata;
   logic               dmem_we;
   logic [DMEM_AW-1:0] dmem_addr;
   logic [63:0]        dmem_wdata;
   logic               core_rst;
   logic               busy;
   logic               err;

   modport master (
      output in_valid, in_data,
      input  in_ready,
      input  imem_we, imem_addr, imem_wdata,
      input  dmem_we, dmem_addr, dmem_wdata,
      input  core_rst, busy, err
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready,
      output imem_we, imem_addr, imem_wdata,
      output dmem_we, dmem_addr, dmem_wdata,
      output core_rst, busy, err
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses host frames into instruction/data memory writes
// and releases the core from reset on the START header.
module program_loader #(
   parameter int IMEM_AW = 12,
   parameter int DMEM_AW = 10
) (
   input logic             clk,
   input logic             rst,
   program_loader_if.slave bus
);
   localparam int AW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;

   typedef enum logic [2:0] {
      IDLE, ADDR_L, ADDR_H, CNT_L, CNT_H, PAYLOAD, RUN
   } state_t;

   state_t      state;
   logic        is_data;
   logic [7:0]  addr_lo;
   logic [AW-1:0] addr;
   logic [15:0] cnt;
   logic [2:0]  bc;
   logic [63:0] sr;
   logic [63:0] word;
   logic        acc;
   logic        last_byte;

   assign acc       = bus.in_valid & bus.in_ready;
   assign last_byte = (bc == (is_data ? 3'd7 : 3'd3));

   // Word including the byte being accepted this cycle
   always_comb begin
      word = sr;
      word[{bc, 3'b000} +: 8] = bus.in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         is_data        <= 1'b0;
         addr_lo        <= '0;
         addr           <= '0;
         cnt            <= '0;
         bc             <= '0;
         sr             <= '0;
         bus.in_ready   <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         bus.dmem_we    <= 1'b0;
         bus.dmem_addr  <= '0;
         bus.dmem_wdata <= '0;
         bus.core_rst   <= 1'b1;
         bus.busy       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.imem_we  <= 1'b0;
         bus.dmem_we  <= 1'b0;
         bus.in_ready <= (state != RUN);
         if (acc) begin
            unique case (state)
               IDLE: begin
                  unique case (1'b1)
                     (bus.in_data == 8'hA5): begin
                        is_data  <= 1'b0;
                        state    <= ADDR_L;
                        bus.busy <= 1'b1;
                     end
                     (bus.in_data == 8'h5A): begin
                        is_data  <= 1'b1;
                        state    <= ADDR_L;
                        bus.busy <= 1'b1;
                     end
                     (bus.in_data == 8'hFF): begin
                        state        <= RUN;
                        bus.core_rst <= 1'b0;
                        bus.in_ready <= 1'b0;
                     end
                     default: bus.err <= 1'b1;
                  endcase
               end
               ADDR_L: begin
                  addr_lo <= bus.in_data;
                  state   <= ADDR_H;
               end
               ADDR_H: begin
                  addr  <= AW'({bus.in_data, addr_lo});
                  state <= CNT_L;
               end
               CNT_L: begin
                  cnt[7:0] <= bus.in_data;
                  state    <= CNT_H;
               end
               CNT_H: begin
                  cnt[15:8] <= bus.in_data;
                  bc        <= '0;
                  if ({bus.in_data, cnt[7:0]} == 16'd0) begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end else begin
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  sr <= word;
                  if (last_byte) begin
                     bc <= '0;
                     if (is_data) begin
                        bus.dmem_we    <= 1'b1;
                        bus.dmem_addr  <= addr[DMEM_AW-1:0];
                        bus.dmem_wdata <= word;
                     end else begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= addr[IMEM_AW-1:0];
                        bus.imem_wdata <= word[31:0];
                     end
                     addr <= addr + AW'(1);
                     cnt  <= cnt - 16'd1;
                     if (cnt == 16'd1) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                     end
                  end else begin
                     bc <= bc + 3'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
